// File: rtl/cache_ctrl.sv
// Sequencing controller for the 2-way set-associative write-back data cache.
// Optional hit/miss statistics are built only when CACHE_STATS_EN is defined.
module cache_ctrl #(
  parameter int SETS  = 8,
  parameter int WORDS = 8,
  parameter int TAG_W = 24
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  output logic                     cpu_ready,
  input  logic [1:0]               way_hit,
  input  logic [1:0]               way_valid,
  input  logic [1:0]               way_dirty,
  input  logic [TAG_W-1:0]         victim_tag,
  output logic                     victim_way,
  output logic                     arr_we,
  output logic                     arr_way,
  output logic [$clog2(WORDS)-1:0] arr_word,
  output logic                     arr_src_mem,
  output logic                     arr_set_dirty,
  output logic                     arr_tag_we,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int OW = $clog2(WORDS);

  // state     | meaning
  // IDLE      | waiting for cpu_req
  // LOOKUP    | tag compare; hit completes, miss picks victim
  // WRITEBACK | streaming dirty victim line to memory
  // FILL      | reading the requested line from memory into the victim way
  // UPDATE    | writing new tag/valid, then re-lookup
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOOKUP    = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] FILL      = 3'd3;
  localparam logic [2:0] UPDATE    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [SETS-1:0]  lru_q, lru_d;
  logic [OW-1:0]    cnt_q, cnt_d;
  logic             victim_q, victim_d;

  logic [IW-1:0]    idx;
  logic [OW-1:0]    word;
  logic [TAG_W-1:0] tag;
  logic             hit, hit_way, victim_sel, cnt_last;
  logic             unused_addr_bits;

  assign idx              = cpu_addr[OW+2 +: IW];
  assign word             = cpu_addr[2 +: OW];
  assign tag              = cpu_addr[31 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr[1:0];
  assign hit              = |way_hit;
  assign hit_way          = way_hit[1];
  assign cnt_last         = &cnt_q;

  // Invalid ways are filled before any valid line is evicted.
  assign victim_sel = !way_valid[0] ? 1'b0 :
                      !way_valid[1] ? 1'b1 : lru_q[idx];

  assign victim_way = (state_q == LOOKUP) ? victim_sel : victim_q;

  always_comb begin
    state_d       = state_q;
    lru_d         = lru_q;
    cnt_d         = cnt_q;
    victim_d      = victim_q;
    cpu_ready     = 1'b0;
    arr_we        = 1'b0;
    arr_way       = 1'b0;
    arr_word      = '0;
    arr_src_mem   = 1'b0;
    arr_set_dirty = 1'b0;
    arr_tag_we    = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          cpu_ready    = 1'b1;
          lru_d[idx]   = ~hit_way;
          state_d      = IDLE;
          if (cpu_we) begin
            arr_we        = 1'b1;
            arr_way       = hit_way;
            arr_word      = word;
            arr_set_dirty = 1'b1;
          end
        end else begin
          victim_d = victim_sel;
          cnt_d    = '0;
          state_d  = (way_valid[victim_sel] && way_dirty[victim_sel]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {victim_tag, idx, cnt_q, 2'b00};
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag, idx, cnt_q, 2'b00};
        if (mem_ack) begin
          arr_we      = 1'b1;
          arr_src_mem = 1'b1;
          arr_way     = victim_q;
          arr_word    = cnt_q;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_last) state_d = UPDATE;
        end
      end
      UPDATE: begin
        arr_tag_we = 1'b1;
        arr_way    = victim_q;
        state_d    = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      lru_q    <= '0;
      cnt_q    <= '0;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lru_q    <= lru_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic        refill_q;
  logic [31:0] hit_count_q, miss_count_q;

  // The lookup right after UPDATE completes a miss and must not count as a hit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      refill_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (state_q == UPDATE)      refill_q <= 1'b1;
      else if (state_q == LOOKUP) refill_q <= 1'b0;
      if (state_q == LOOKUP && hit && !refill_q) hit_count_q  <= hit_count_q + 32'd1;
      if (state_q == LOOKUP && !hit)             miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a small tag/valid/dirty array model.
// Statistics expectations follow CACHE_STATS_EN.
module tb_cache_ctrl;
  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic [1:0]  way_hit, way_valid, way_dirty;
  logic [23:0] victim_tag;
  logic        victim_way, arr_we, arr_way, arr_src_mem, arr_set_dirty, arr_tag_we;
  logic [2:0]  arr_word;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, hit_count, miss_count;

  always #5 CLK = ~CLK;

  cache_ctrl dut (
    .CLK(CLK), .RST(RST), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
    .victim_tag(victim_tag), .victim_way(victim_way), .arr_we(arr_we), .arr_way(arr_way),
    .arr_word(arr_word), .arr_src_mem(arr_src_mem), .arr_set_dirty(arr_set_dirty),
    .arr_tag_we(arr_tag_we), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Tag array model
  logic [23:0] tag_m   [8][2];
  logic [1:0]  valid_m [8];
  logic [1:0]  dirty_m [8];
  logic [2:0]  ci;
  assign ci = cpu_addr[7:5];
  assign way_valid  = valid_m[ci];
  assign way_dirty  = dirty_m[ci];
  assign way_hit    = {valid_m[ci][1] && (tag_m[ci][1] == cpu_addr[31:8]),
                       valid_m[ci][0] && (tag_m[ci][0] == cpu_addr[31:8])};
  assign victim_tag = tag_m[ci][victim_way];

  always @(posedge CLK) begin
    if (arr_tag_we) begin
      tag_m[ci][arr_way]   <= cpu_addr[31:8];
      valid_m[ci][arr_way] <= 1'b1;
      dirty_m[ci][arr_way] <= 1'b0;
    end
    if (arr_we && arr_set_dirty) dirty_m[ci][arr_way] <= 1'b1;
  end

  // Memory responder and transaction logs
  logic ack_en;
  assign mem_ack = ack_en & mem_req;

  int          wr_n, rd_n, fill_n, tagwe_n, mreq_cycles;
  logic [31:0] wr_log [32];
  logic [31:0] rd_log [32];
  logic        fill_way_log  [32];
  logic [2:0]  fill_word_log [32];

  always @(posedge CLK) begin
    if (mem_req) mreq_cycles++;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        if (wr_n < 32) wr_log[wr_n] = mem_addr;
        wr_n++;
      end else begin
        if (rd_n < 32) rd_log[rd_n] = mem_addr;
        rd_n++;
      end
    end
    if (arr_we && arr_src_mem) begin
      if (fill_n < 32) begin
        fill_way_log[fill_n]  = arr_way;
        fill_word_log[fill_n] = arr_word;
      end
      fill_n++;
    end
    if (arr_tag_we) tagwe_n++;
  end

  logic s_we, s_way, s_dirty, s_src;
  logic [2:0] s_word;

  task automatic clear_logs();
    wr_n = 0; rd_n = 0; fill_n = 0; tagwe_n = 0; mreq_cycles = 0;
  endtask

  // Drives one request; cyc counts cycles with the request cycle as cycle 1, 0 on timeout.
  task automatic access(input logic [31:0] a, input logic we, output int cyc);
    @(negedge CLK);
    clear_logs();
    cpu_addr = a; cpu_we = we; cpu_req = 1'b1;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (cpu_ready) begin
        cyc = i + 2;
        s_we = arr_we; s_way = arr_way; s_word = arr_word;
        s_dirty = arr_set_dirty; s_src = arr_src_mem;
        break;
      end
    end
    @(negedge CLK);
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (cpu_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_cpu_ready got %b want 0", cpu_ready); end
    n_checks++; if (mem_req !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_checks++; if (arr_we !== 1'b0)     begin n_fail++; $display("FAIL reset_arr_we got %b want 0", arr_we); end
    n_checks++; if (arr_tag_we !== 1'b0) begin n_fail++; $display("FAIL reset_arr_tag_we got %b want 0", arr_tag_we); end
    n_checks++; if (victim_way !== 1'b0) begin n_fail++; $display("FAIL reset_victim_way got %b want 0", victim_way); end
    n_checks++; if (mem_addr !== 32'h0)  begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_checks++; if (hit_count !== 32'h0) begin n_fail++; $display("FAIL reset_hit_count got %0d want 0", hit_count); end
    n_checks++; if (miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_miss_count got %0d want 0", miss_count); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_cold_load();
    int cyc;
    access(32'h0000_0120, 1'b0, cyc);
    n_checks++; if (cyc !== 12) begin n_fail++; $display("FAIL cold_latency got %0d want 12", cyc); end
    n_checks++; if (wr_n !== 0) begin n_fail++; $display("FAIL cold_writes got %0d want 0", wr_n); end
    n_checks++; if (rd_n !== 8) begin n_fail++; $display("FAIL cold_reads got %0d want 8", rd_n); end
    n_checks++; if (fill_n !== 8) begin n_fail++; $display("FAIL cold_fill_count got %0d want 8", fill_n); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rd_log[i] !== 32'h120 + 32'(4*i)) begin n_fail++; $display("FAIL cold_rd_addr[%0d] got %h want %h", i, rd_log[i], 32'h120 + 32'(4*i)); end
      n_checks++; if (fill_way_log[i] !== 1'b0) begin n_fail++; $display("FAIL cold_fill_way[%0d] got %b want 0", i, fill_way_log[i]); end
      n_checks++; if (fill_word_log[i] !== 3'(i)) begin n_fail++; $display("FAIL cold_fill_word[%0d] got %0d want %0d", i, fill_word_log[i], i); end
    end
    n_checks++; if (tagwe_n !== 1) begin n_fail++; $display("FAIL cold_tag_we got %0d want 1", tagwe_n); end
    n_checks++; if (tag_m[1][0] !== 24'h000001) begin n_fail++; $display("FAIL cold_tag got %h want 000001", tag_m[1][0]); end
    n_checks++; if (valid_m[1] !== 2'b01) begin n_fail++; $display("FAIL cold_valid got %b want 01", valid_m[1]); end
  endtask

  task automatic test_load_hit();
    int cyc;
    access(32'h0000_0124, 1'b0, cyc);
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL load_hit_latency got %0d want 2", cyc); end
    n_checks++; if (mreq_cycles !== 0) begin n_fail++; $display("FAIL load_hit_mem_req got %0d want 0", mreq_cycles); end
    n_checks++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL load_hit_arr_we got %b want 0", s_we); end
  endtask

  task automatic test_store_hit();
    int cyc;
    access(32'h0000_0128, 1'b1, cyc);
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL store_hit_latency got %0d want 2", cyc); end
    n_checks++; if (s_we !== 1'b1) begin n_fail++; $display("FAIL store_hit_arr_we got %b want 1", s_we); end
    n_checks++; if (s_way !== 1'b0) begin n_fail++; $display("FAIL store_hit_arr_way got %b want 0", s_way); end
    n_checks++; if (s_word !== 3'd2) begin n_fail++; $display("FAIL store_hit_arr_word got %0d want 2", s_word); end
    n_checks++; if (s_dirty !== 1'b1) begin n_fail++; $display("FAIL store_hit_set_dirty got %b want 1", s_dirty); end
    n_checks++; if (s_src !== 1'b0) begin n_fail++; $display("FAIL store_hit_src_mem got %b want 0", s_src); end
    n_checks++; if (mreq_cycles !== 0) begin n_fail++; $display("FAIL store_hit_mem_req got %0d want 0", mreq_cycles); end
  endtask

  task automatic test_store_miss();
    int cyc;
    access(32'h0000_0328, 1'b1, cyc);
    n_checks++; if (cyc !== 12) begin n_fail++; $display("FAIL store_miss_latency got %0d want 12", cyc); end
    n_checks++; if (wr_n !== 0) begin n_fail++; $display("FAIL store_miss_writes got %0d want 0", wr_n); end
    n_checks++; if (rd_log[0] !== 32'h320) begin n_fail++; $display("FAIL store_miss_rd0 got %h want 320", rd_log[0]); end
    n_checks++; if (fill_way_log[0] !== 1'b1) begin n_fail++; $display("FAIL store_miss_fill_way got %b want 1", fill_way_log[0]); end
    n_checks++; if (s_we !== 1'b1 || s_way !== 1'b1 || s_word !== 3'd2 || s_dirty !== 1'b1)
      begin n_fail++; $display("FAIL store_miss_final_write got we=%b way=%b word=%0d dirty=%b want 1 1 2 1", s_we, s_way, s_word, s_dirty); end
  endtask

  task automatic test_dirty_miss();
    int cyc;
    logic [31:0] exp_hit, exp_miss;
    access(32'h0000_0520, 1'b0, cyc);
    n_checks++; if (cyc !== 20) begin n_fail++; $display("FAIL dirty_latency got %0d want 20", cyc); end
    n_checks++; if (wr_n !== 8) begin n_fail++; $display("FAIL dirty_writes got %0d want 8", wr_n); end
    n_checks++; if (rd_n !== 8) begin n_fail++; $display("FAIL dirty_reads got %0d want 8", rd_n); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (wr_log[i] !== 32'h120 + 32'(4*i)) begin n_fail++; $display("FAIL dirty_wr_addr[%0d] got %h want %h", i, wr_log[i], 32'h120 + 32'(4*i)); end
      n_checks++; if (rd_log[i] !== 32'h520 + 32'(4*i)) begin n_fail++; $display("FAIL dirty_rd_addr[%0d] got %h want %h", i, rd_log[i], 32'h520 + 32'(4*i)); end
      n_checks++; if (fill_way_log[i] !== 1'b0) begin n_fail++; $display("FAIL dirty_fill_way[%0d] got %b want 0", i, fill_way_log[i]); end
    end
    n_checks++; if (tag_m[1][0] !== 24'h000005) begin n_fail++; $display("FAIL dirty_new_tag got %h want 000005", tag_m[1][0]); end
`ifdef CACHE_STATS_EN
    exp_hit = 32'd2; exp_miss = 32'd3;
`else
    exp_hit = 32'd0; exp_miss = 32'd0;
`endif
    n_checks++; if (hit_count !== exp_hit) begin n_fail++; $display("FAIL stats_hits_pre got %0d want %0d", hit_count, exp_hit); end
    n_checks++; if (miss_count !== exp_miss) begin n_fail++; $display("FAIL stats_misses_pre got %0d want %0d", miss_count, exp_miss); end
  endtask

  task automatic test_reset_mid_wb();
    bit found = 1'b0;
    @(negedge CLK);
    clear_logs();
    cpu_addr = 32'h0000_0720; cpu_we = 1'b0; cpu_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (wr_n == 4) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rst_wb_reach got writes=%0d want 4", wr_n); end
    n_checks++; if (mem_addr !== 32'h330 || mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_wb_addr got %h we=%b want 330 we=1", mem_addr, mem_we); end
    ack_en = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h330) begin n_fail++; $display("FAIL rst_wb_hold got req=%b addr=%h want 1 330", mem_req, mem_addr); end
    n_checks++; if (wr_n !== 4) begin n_fail++; $display("FAIL rst_wb_hold_writes got %0d want 4", wr_n); end
    @(negedge CLK);
    RST = 1'b1; cpu_req = 1'b0;
    @(posedge CLK); #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_wb_mem_req got %b want 0", mem_req); end
    n_checks++; if (cpu_ready !== 1'b0 || arr_we !== 1'b0 || victim_way !== 1'b0)
      begin n_fail++; $display("FAIL rst_wb_outputs got ready=%b arr_we=%b victim=%b want 0 0 0", cpu_ready, arr_we, victim_way); end
    n_checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_fail++; $display("FAIL rst_wb_stats got %0d %0d want 0 0", hit_count, miss_count); end
    @(negedge CLK);
    RST = 1'b0; ack_en = 1'b1;
  endtask

  task automatic test_after_reset();
    int cyc;
    logic [31:0] exp_hit, exp_miss;
    // lru cleared: victim is clean way0, not dirty way1
    access(32'h0000_0720, 1'b0, cyc);
    n_checks++; if (cyc !== 12) begin n_fail++; $display("FAIL post_rst_latency got %0d want 12", cyc); end
    n_checks++; if (wr_n !== 0) begin n_fail++; $display("FAIL post_rst_writes got %0d want 0", wr_n); end
    n_checks++; if (fill_way_log[0] !== 1'b0) begin n_fail++; $display("FAIL post_rst_fill_way got %b want 0", fill_way_log[0]); end
    n_checks++; if (rd_log[7] !== 32'h73C) begin n_fail++; $display("FAIL post_rst_rd7 got %h want 73c", rd_log[7]); end
    for (int i = 1; i < 4; i++) begin
      access(32'h0000_0720 + 32'(4*i), 1'b0, cyc);
      n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL post_rst_hit%0d_latency got %0d want 2", i, cyc); end
    end
`ifdef CACHE_STATS_EN
    exp_hit = 32'd3; exp_miss = 32'd1;
`else
    exp_hit = 32'd0; exp_miss = 32'd0;
`endif
    n_checks++; if (hit_count !== exp_hit) begin n_fail++; $display("FAIL stats_hits got %0d want %0d", hit_count, exp_hit); end
    n_checks++; if (miss_count !== exp_miss) begin n_fail++; $display("FAIL stats_misses got %0d want %0d", miss_count, exp_miss); end
  endtask

  initial begin
    for (int s = 0; s < 8; s++) begin
      valid_m[s] = 2'b00; dirty_m[s] = 2'b00;
      tag_m[s][0] = 24'h0; tag_m[s][1] = 24'h0;
    end
    RST = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; ack_en = 1'b1;
    clear_logs();
    test_reset();
    test_cold_load();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_dirty_miss();
    test_reset_mid_wb();
    test_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Sequencing controller for the OTTER 2-way set-associative, write-back, write-allocate data cache (8 sets x 8 words/line).
- Takes single CPU requests and evaluates hit/miss from the tag-array compare results.
- Keeps per-set LRU state and picks the victim way.
- Drives word-by-word writeback and line fill against main memory, plus array write strobes.
- Sits between the CPU memory stage, the cache tag/data arrays and the main-memory port.

Parameters:
SETS, 8, number of sets (index width = log2(SETS))
WORDS, 8, 32-bit words per line (offset width = log2(WORDS))
TAG_W, 24, tag width = 32 - 2 - log2(WORDS) - log2(SETS)

Ports:
CLK  in  1  clock; all state changes on the rising edge
RST  in  1  synchronous, active-high reset
cpu_req  in  1  access request; cpu_addr and cpu_we held stable until cpu_ready
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address: tag [31:8], index [7:5], word [4:2]
cpu_ready  out  1  one-cycle pulse: access complete (load data valid from arrays / store written)
way_hit  in  2  per-way tag match AND valid for the indexed set (combinational from arrays)
way_valid  in  2  valid bits of the indexed set
way_dirty  in  2  dirty bits of the indexed set
victim_tag  in  TAG_W  stored tag of way victim_way in the indexed set
victim_way  out  1  selected victim way (array read mux select)
arr_we  out  1  write one data word into the arrays
arr_way  out  1  way for arr_we / arr_tag_we
arr_word  out  3  word offset for arr_we (CPU data on store hit, mem_rdata on fill)
arr_src_mem  out  1  1 = arr_we data from memory, 0 = from CPU
arr_set_dirty  out  1  with arr_we on store hit: set dirty bit
arr_tag_we  out  1  write tag = cpu_addr[31:8], valid = 1, dirty = 0 into arr_way
mem_req  out  1  memory word request
mem_we  out  1  1 = writeback word, 0 = fill read
mem_addr  out  32  word-aligned memory address
mem_ack  in  1  memory accepted / returned the current word
hit_count  out  32  hit counter (see Optional Feature)
miss_count  out  32  miss counter (see Optional Feature)

Behaviour:
- Reset (any state): state = IDLE, LRU = 0 for all sets, word counter = 0. All outputs 0 from the cycle after RST is sampled, and any in-flight burst is abandoned (mem_req drops).
- States: IDLE, LOOKUP, WRITEBACK, FILL, UPDATE.
- IDLE: cpu_req = 1 -> LOOKUP. mem_ack is ignored.
- LOOKUP, hit (way_hit != 0; way1 used if both bits are set):
  - cpu_ready = 1.
  - lru[index] <= ~hit_way.
  - If store: arr_we = 1, arr_way = hit way, arr_word = cpu_addr[4:2], arr_src_mem = 0, arr_set_dirty = 1.
  - -> IDLE. Hit latency is 2 cycles from cpu_req to cpu_ready.
- Victim selection (combinational, used in LOOKUP): way0 if !way_valid[0], else way1 if !way_valid[1], else lru[index]. victim_way is registered on entry to WRITEBACK/FILL and held until UPDATE completes.
- LOOKUP, miss: -> WRITEBACK if way_valid[v] & way_dirty[v], else -> FILL. Word counter cleared.
- WRITEBACK:
  - mem_req = 1, mem_we = 1, mem_addr = {victim_tag, index, cnt, 2'b00}.
  - On mem_ack: cnt++. Ack on cnt = 7 -> FILL with cnt = 0.
- FILL:
  - mem_req = 1, mem_we = 0, mem_addr = {cpu_addr[31:8], index, cnt, 2'b00}.
  - On mem_ack: arr_we = 1, arr_src_mem = 1, arr_way = victim, arr_word = cnt, cnt++.
  - Ack on cnt = 7 -> UPDATE.
- UPDATE: arr_tag_we = 1, arr_way = victim -> LOOKUP. The re-lookup hits and completes the access; a store is written and marked dirty there.
- mem_req stays high across consecutive words. Without mem_ack the state holds indefinitely with outputs stable.
- cpu_req deasserting mid-miss is a protocol violation; behaviour is undefined.
- Miss latency: clean miss = 2 + 8 fill acks + 2 cycles; dirty miss adds 8 writeback acks.
- cpu_ready never asserts outside LOOKUP.

Optional Feature:
CACHE_STATS_EN
- Defined: hit_count increments on each LOOKUP hit that is not a post-fill re-lookup; miss_count increments on each LOOKUP miss. Both are 32-bit, wrap at 2^32-1 -> 0, and clear on RST.
- Not defined: counter logic is not built; hit_count and miss_count are tied to 0.

Test Plan:
- Cold load at 0x0000_0120 (index 1, word 0), all invalid, mem_ack every cycle -> FILL of 0x120..0x13C into way0, arr_tag_we with tag 0x000001, cpu_ready at cycle 12, lru[1] = 1.
- Repeat load 0x0000_0124 after the fill, way_hit = 2'b01 -> cpu_ready 2 cycles after cpu_req, no mem_req.
- Store hit at 0x0000_0128 -> arr_we = 1, arr_way = 0, arr_word = 2, arr_set_dirty = 1, cpu_ready same cycle.
- Set 1 full, both dirty, lru[1] = 0, load 0x0000_0520 -> 8 writes at {victim_tag, 3'd1, cnt, 00}, then 8 fill reads from 0x520, way0 replaced.
- RST asserted during WRITEBACK cnt = 4 -> next cycle mem_req = 0, state IDLE, lru all 0.
- With CACHE_STATS_EN: 1 cold miss then 3 hits -> miss_count = 1, hit_count = 3.
